// File: rtl/hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// hazard_controller_pkg
//   Shared types and helpers for the pipeline hazard controller.
//   - hz_state_t     : sequencer states (RUN / MC_WAIT / MC_DONE / REDIRECT)
//   - hz_cnt_width() : width of the shared down-counter so that it can hold
//                      both the multi-cycle preload and the redirect shadow.
//   - HZ_PERF_W      : width of the optional performance counters
//                      (present only when HAZARD_PERF_CNT_EN is defined).
// -----------------------------------------------------------------------------
package hazard_controller_pkg;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MC_WAIT  = 2'd1,
      HZ_MC_DONE  = 2'd2,
      HZ_REDIRECT = 2'd3
   } hz_state_t;

   localparam int unsigned HZ_PERF_W = 32;

   // Counter must represent values up to max(MC_LATENCY, REDIRECT_SHADOW+1).
   function automatic int unsigned hz_cnt_width(input int unsigned mc_latency,
                                                input int unsigned shadow);
      int unsigned span;
      span = (mc_latency > shadow + 1) ? mc_latency : shadow + 1;
      return (span < 2) ? 1 : $clog2(span + 1);
   endfunction

endpackage

// File: rtl/hazard_controller_load_use_detect.sv
// -----------------------------------------------------------------------------
// hazard_controller_load_use_detect  (the load_use_detect block)
//   Purely combinational load-use hazard detector. Flags when the instruction
//   in ID reads a register that the load currently in EX will write.
//   Ports:
//     id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2 : ID instruction fields
//     ex_valid, ex_rd, ex_mem_read                         : EX instruction fields
//     lu                                                   : load-use hazard
// -----------------------------------------------------------------------------
module hazard_controller_load_use_detect
   import hazard_controller_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       lu
);

   logic load_in_ex;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      // x0 is never written, so a load to x0 can never create a hazard.
      load_in_ex = ex_valid & ex_mem_read & (ex_rd != 5'd0);
      rs1_hit    = id_uses_rs1 & (id_rs1 == ex_rd);
      rs2_hit    = id_uses_rs2 & (id_rs2 == ex_rd);
      lu         = load_in_ex & id_valid & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Central sequencer for the 5-stage RISC-V pipeline. Produces stall/flush
//   controls for IF/ID and ID/EX covering load-use bubbles, taken-branch/jump
//   redirects with an IMEM fetch shadow, and multi-cycle EX (mul/div) holds.
//   Outputs are combinational from state, counter and inputs (zero latency)
//   and are forced to 0 while rst is high.
//
//   Parameters:
//     MC_LATENCY      : total EX cycles of a multi-cycle op (2..64)
//     REDIRECT_SHADOW : extra flush_if cycles after a redirect (0..7)
//
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     id_*                : instruction in ID (valid, sources, source usage)
//     ex_valid, ex_rd     : instruction in EX
//     ex_mem_read         : EX instruction is a load
//     ex_redirect         : EX resolved a taken branch / JAL / JALR
//     ex_mc_start         : EX instruction is a multi-cycle op
//     stall_if, stall_id  : hold PC+IF/ID, hold ID/EX
//     flush_if, flush_id  : bubble IF/ID, bubble ID/EX (flush_id beats stall_id)
//     ex_hold             : multi-cycle unit busy, EX/MEM captures a bubble
//     mc_done             : release-cycle pulse of a multi-cycle op
//
//   Optional feature (macro HAZARD_PERF_CNT_EN):
//     perf_stall_cycles   : cycles with stall_if high (wraps at 2^32)
//     perf_flush_events   : accepted redirects (wraps at 2^32)
// -----------------------------------------------------------------------------
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int unsigned MC_LATENCY      = 4,
   parameter int unsigned REDIRECT_SHADOW = 1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic       ex_redirect,
   input  logic       ex_mc_start,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_if,
   output logic       flush_id,
   output logic       ex_hold,
   output logic       mc_done
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [HZ_PERF_W-1:0] perf_stall_cycles,
   output logic [HZ_PERF_W-1:0] perf_flush_events
`endif
);

   localparam int unsigned CW = hz_cnt_width(MC_LATENCY, REDIRECT_SHADOW);

   // Preload values; guarded so the unused branch never underflows.
   localparam logic [CW-1:0] MC_PRELOAD =
      CW'((MC_LATENCY > 2) ? (MC_LATENCY - 3) : 0);
   localparam logic [CW-1:0] RD_PRELOAD =
      CW'((REDIRECT_SHADOW > 0) ? (REDIRECT_SHADOW - 1) : 0);

   hz_state_t     state;
   hz_state_t     state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   logic lu;
   logic redir;
   logic mc;

   hazard_controller_load_use_detect u_load_use_detect (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .lu          (lu)
   );

   always_comb begin
      redir = ex_valid & ex_redirect;
      mc    = ex_valid & ex_mc_start;
   end

   // Output and next-state decode. RUN and MC_DONE share the redirect and
   // load-use handling; MC_DONE only differs by raising mc_done, ignoring a
   // new multi-cycle request and falling back to RUN.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      ex_hold   = 1'b0;
      mc_done   = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;

      unique case (state)
         HZ_RUN, HZ_MC_DONE: begin
            mc_done   = (state == HZ_MC_DONE);
            state_nxt = HZ_RUN;
            if (redir) begin
               flush_if = 1'b1;
               flush_id = 1'b1;
               if (REDIRECT_SHADOW > 0) begin
                  state_nxt = HZ_REDIRECT;
                  cnt_nxt   = RD_PRELOAD;
               end
            end else if (mc && (state == HZ_RUN)) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               ex_hold  = 1'b1;
               if (MC_LATENCY == 2) begin
                  state_nxt = HZ_MC_DONE;
               end else begin
                  state_nxt = HZ_MC_WAIT;
                  cnt_nxt   = MC_PRELOAD;
               end
            end else if (lu) begin
               // Hold the consumer in IF/ID, push a bubble into ID/EX.
               stall_if = 1'b1;
               flush_id = 1'b1;
            end
         end

         HZ_MC_WAIT: begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            ex_hold  = 1'b1;
            if (cnt == '0) begin
               state_nxt = HZ_MC_DONE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end

         HZ_REDIRECT: begin
            // Wrong-path fetches still arriving from IMEM: keep squashing.
            flush_if = 1'b1;
            if (cnt == '0) begin
               state_nxt = HZ_RUN;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end

         default: begin
            state_nxt = HZ_RUN;
            cnt_nxt   = '0;
         end
      endcase

      // Reset forces every control low immediately, independent of state.
      if (rst) begin
         stall_if = 1'b0;
         stall_id = 1'b0;
         flush_if = 1'b0;
         flush_id = 1'b0;
         ex_hold  = 1'b0;
         mc_done  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HZ_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic redir_accepted;

   always_comb begin
      redir_accepted = redir & ((state == HZ_RUN) | (state == HZ_MC_DONE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_events <= '0;
      end else begin
         if (stall_if) begin
            perf_stall_cycles <= perf_stall_cycles + HZ_PERF_W'(1);
         end
         if (redir_accepted) begin
            perf_flush_events <= perf_flush_events + HZ_PERF_W'(1);
         end
      end
   end
`else
   // Performance counters not built.
`endif

   // A redirect and a multi-cycle start in the same EX slot is illegal;
   // the redirect wins in the decode above.
   a_redir_mc_exclusive: assert property (
      @(posedge clk) disable iff (rst) !(redir && mc)
   );

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   localparam int unsigned MC_LATENCY      = 4;
   localparam int unsigned REDIRECT_SHADOW = 1;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       ex_valid;
   logic [4:0] ex_rd;
   logic       ex_mem_read;
   logic       ex_redirect;
   logic       ex_mc_start;
   logic       stall_if;
   logic       stall_id;
   logic       flush_if;
   logic       flush_id;
   logic       ex_hold;
   logic       mc_done;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_events;
`endif

   hazard_controller #(
      .MC_LATENCY      (MC_LATENCY),
      .REDIRECT_SHADOW (REDIRECT_SHADOW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .ex_redirect (ex_redirect),
      .ex_mc_start (ex_mc_start),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .flush_if    (flush_if),
      .flush_id    (flush_id),
      .ex_hold     (ex_hold),
      .mc_done     (mc_done)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_events (perf_flush_events)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: remaining shadow cycles, remaining hold cycles after
   // the current one, and whether the current cycle is the release cycle.
   int          m_shadow = 0;
   int          m_hold   = 0;
   bit          m_done   = 1'b0;
   logic [31:0] m_stall  = '0;
   logic [31:0] m_flush  = '0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_in();
      id_valid    = 1'b0;
      id_rs1      = '0;
      id_rs2      = '0;
      id_uses_rs1 = 1'b0;
      id_uses_rs2 = 1'b0;
      ex_valid    = 1'b0;
      ex_rd       = '0;
      ex_mem_read = 1'b0;
      ex_redirect = 1'b0;
      ex_mc_start = 1'b0;
   endtask

   // Called at posedge+1 with inputs applied; checks mid-cycle, advances
   // the model across the next rising edge, returns at posedge+1.
   // exp bits: [5]stall_if [4]stall_id [3]flush_if [2]flush_id [1]ex_hold [0]mc_done
   task automatic run_cycle(input string tag);
      logic [5:0] exp;
      logic [5:0] got;
      int         n_shadow;
      int         n_hold;
      bit         n_done;
      bit         f_inc;
      bit         lu_m;
      bit         redir_m;
      bit         mc_m;
      #3;
      lu_m    = ex_valid && ex_mem_read && (ex_rd != 0) && id_valid &&
                ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      redir_m = ex_valid && ex_redirect;
      mc_m    = ex_valid && ex_mc_start;
      exp      = '0;
      n_shadow = m_shadow;
      n_hold   = m_hold;
      n_done   = 1'b0;
      f_inc    = 1'b0;
      if (rst) begin
         n_shadow = 0;
         n_hold   = 0;
      end else if (m_shadow > 0) begin
         exp[3]   = 1'b1;
         n_shadow = m_shadow - 1;
      end else if (m_hold > 0) begin
         exp[5] = 1'b1; exp[4] = 1'b1; exp[1] = 1'b1;
         n_hold = m_hold - 1;
         n_done = (n_hold == 0);
      end else begin
         exp[0] = m_done;
         if (redir_m) begin
            exp[3]   = 1'b1; exp[2] = 1'b1;
            n_shadow = REDIRECT_SHADOW;
            f_inc    = 1'b1;
         end else if (mc_m && !m_done) begin
            exp[5] = 1'b1; exp[4] = 1'b1; exp[1] = 1'b1;
            n_hold = MC_LATENCY - 2;
            n_done = (MC_LATENCY == 2);
         end else if (lu_m) begin
            exp[5] = 1'b1; exp[2] = 1'b1;
         end
      end
      got = {stall_if, stall_id, flush_if, flush_id, ex_hold, mc_done};
      check_eq(tag, 32'(got), 32'(exp));
`ifdef HAZARD_PERF_CNT_EN
      check_eq({tag, ".pstall"}, perf_stall_cycles, rst ? 32'd0 : m_stall);
      check_eq({tag, ".pflush"}, perf_flush_events, rst ? 32'd0 : m_flush);
`endif
      @(posedge clk);
      if (rst) begin
         m_stall = '0;
         m_flush = '0;
         m_done  = 1'b0;
      end else begin
         m_stall = m_stall + 32'(exp[5]);
         m_flush = m_flush + 32'(f_inc);
         m_done  = n_done;
      end
      m_shadow = n_shadow;
      m_hold   = n_hold;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      @(posedge clk);
      #1;
      run_cycle("reset");
      rst = 1'b0;
      run_cycle("idle");

      // Load-use on rs1, then bubble drains.
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
      id_valid = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      run_cycle("t1.lu");
      ex_valid = 1'b0;
      run_cycle("t1.after");

      // Load to x0, and an unused matching rs2: no hazard.
      clear_in();
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
      id_valid = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      run_cycle("t2.x0");
      ex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
      run_cycle("t2.rs2_unused");

      // Multi-cycle op: 3 hold cycles, then release pulse, then RUN.
      clear_in();
      ex_valid = 1'b1; ex_mc_start = 1'b1;
      for (int i = 0; i < 3; i++) run_cycle("t3.hold");
      ex_mc_start = 1'b0; ex_valid = 1'b0;
      run_cycle("t3.done");
      run_cycle("t3.run");
`ifdef HAZARD_PERF_CNT_EN
      check_eq("t6.pstall", perf_stall_cycles, 32'd4);
      check_eq("t6.pflush", perf_flush_events, 32'd0);
`endif

      // Redirect together with load-use, then shadow ignores load-use.
      ex_valid = 1'b1; ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
      id_valid = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
      run_cycle("t4.redir");
      ex_redirect = 1'b0;
      run_cycle("t4.shadow");
      clear_in();
      run_cycle("t4.idle");
`ifdef HAZARD_PERF_CNT_EN
      check_eq("t6.pflush1", perf_flush_events, 32'd1);
`endif

      // Reset in the middle of a multi-cycle op.
      ex_valid = 1'b1; ex_mc_start = 1'b1;
      run_cycle("t5.start");
      rst = 1'b1;
      run_cycle("t5.rst");
      rst = 1'b0;
      clear_in();
      run_cycle("t5.post0");
      run_cycle("t5.post1");

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 99) < 2);
         id_valid    = 1'($urandom_range(0, 3) != 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom_range(0, 1));
         id_uses_rs2 = 1'($urandom_range(0, 1));
         ex_valid    = 1'($urandom_range(0, 3) != 0);
         ex_rd       = 5'($urandom_range(0, 3));
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 5) == 0);
         ex_mc_start = ($urandom_range(0, 5) == 0) && !ex_redirect;
         run_cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. It generates stall and flush controls for the IF/ID and ID/EX registers, which are driven into the decode stage's stall/flush inputs. It handles load-use bubbles, taken-branch/jump redirects (including an instruction-fetch shadow), and a multi-cycle EX unit (mul/div) hold.

Parameters:
MC_LATENCY, 4, total EX cycles of a multi-cycle op; legal range 2..64.
REDIRECT_SHADOW, 1, extra cycles flush_if stays high after a redirect (covers IMEM latency); legal range 0..7.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
id_valid  in  1  IF/ID holds a valid instruction.
id_rs1  in  5  rs1 of the instruction in ID.
id_rs2  in  5  rs2 of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_valid  in  1  ID/EX holds a valid instruction.
ex_rd  in  5  rd of the EX instruction.
ex_mem_read  in  1  EX instruction is a load.
ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
ex_mc_start  in  1  EX instruction is a multi-cycle op; stays high while it is held.
stall_if  out  1  hold PC and IF/ID.
stall_id  out  1  hold ID/EX.
flush_if  out  1  clear IF/ID to a bubble.
flush_id  out  1  clear ID/EX to a bubble; has priority over stall_id in ID.
ex_hold  out  1  multi-cycle unit busy; EX/MEM captures a bubble.
mc_done  out  1  single-cycle pulse in the release cycle of a multi-cycle op.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- State machine states: RUN, MC_WAIT, MC_DONE, REDIRECT. A down-counter cnt is sized for max(MC_LATENCY, REDIRECT_SHADOW+1).
- Reset: state=RUN, cnt=0.
  - While rst is high, every output is 0.
- Outputs are combinational from state, cnt and inputs. There is zero-cycle latency to the pipeline registers.
- Load-use condition:
  - lu = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- redir = ex_valid & ex_redirect.
- mc = ex_valid & ex_mc_start.
- RUN, priority redir > mc > lu:
  - redir: flush_if=1 and flush_id=1. Next state is REDIRECT with cnt=REDIRECT_SHADOW-1 if REDIRECT_SHADOW>0, else RUN.
  - mc: stall_if=1, stall_id=1, ex_hold=1. Next state is MC_DONE if MC_LATENCY==2, else MC_WAIT with cnt=MC_LATENCY-3.
  - lu: stall_if=1 and flush_id=1 (bubble inserted); stall_id=0. State stays RUN.
  - None of the above: all outputs 0.
- MC_WAIT:
  - stall_if=1, stall_id=1, ex_hold=1.
  - redir and lu are ignored.
  - If cnt==0, next state is MC_DONE; otherwise cnt decrements.
- MC_DONE:
  - mc_done=1 and ex_hold=0.
  - mc is ignored.
  - redir and lu are evaluated exactly as in RUN, with the same next-state rules; otherwise next state is RUN.
- REDIRECT:
  - flush_if=1 only.
  - lu, mc and redir are all ignored (wrong-path instructions or bubbles).
  - If cnt==0, next state is RUN; otherwise cnt decrements.
- Total hold cycles for a multi-cycle op = MC_LATENCY-1, followed by 1 mc_done cycle.
- Protocol violation: redir and mc high together. Redir wins; a simulation-only assertion flags the violation.
- Reset asserted mid-operation: outputs drop to 0 immediately and state returns to RUN. Any partial multi-cycle op is abandoned.

Optional Feature:
Macro: HAZARD_PERF_CNT_EN.
- When defined, two output ports are added:
  - perf_stall_cycles, 32-bit: increments each cycle stall_if=1.
  - perf_flush_events, 32-bit: increments on each redir accepted.
- Both counters wrap at 2^32 and are cleared by rst.
- When not defined, the ports and counters are absent. Stall/flush behaviour is identical in both cases.

Decomposition:
- riscv_pkg.v gains the state encodings `HZ_RUN=2'd0, `HZ_MC_WAIT=2'd1, `HZ_MC_DONE=2'd2, `HZ_REDIRECT=2'd3.
- One sub-module, load_use_detect: purely combinational, producing lu from the ID/EX fields above.
- FSM, counter and perf counters stay in hazard_controller.

Test Plan:
1. Load-use: ex lw rd=5 valid, ID add rs1=5 with id_uses_rs1=1 -> stall_if=1, flush_id=1, stall_id=0 that cycle. The next cycle, with ex_valid=0, all outputs are 0.
2. Load to x0: ex_rd=0, ex_mem_read=1, id_rs1=0 -> no stall, all outputs 0. Same result when id_uses_rs2=0 and id_rs2 matches ex_rd.
3. Multi-cycle op, MC_LATENCY=4, ex_mc_start high from cycle 10 -> stall_if, stall_id and ex_hold are 1 in cycles 10-12. mc_done=1 in cycle 13 with no stalls; cycle 14 is back in RUN.
4. Redirect with a same-cycle load-use, REDIRECT_SHADOW=1:
   - Cycle t: flush_if=1, flush_id=1, stall_if=0.
   - Cycle t+1: only flush_if=1, even with lu true.
   - Cycle t+2: all outputs 0.
5. Reset during MC_WAIT: rst rises in cycle 11 of test 3 -> all outputs are 0 the same cycle. After release with ex_mc_start=0, state is RUN and there is no mc_done.
6. With HAZARD_PERF_CNT_EN: run tests 1 and 3 back-to-back -> perf_stall_cycles=4, perf_flush_events=0. A subsequent redirect sets perf_flush_events=1.
